// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: turns a counted big-endian byte stream
// into one-cycle word writes for the core's init port, holding the core in init mode.
module imem_loader #(
   parameter int MAX_WORDS = 4096,
   parameter int ADDR_W    = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              init_mode,
   output logic              write_enable,
   output logic [ADDR_W-1:0] init_address,
   output logic [31:0]       init_instruction,
   output logic [ADDR_W:0]   words_written,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0]   MAX_N   = 17'(MAX_WORDS);
   localparam logic [ADDR_W:0] W_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic [7:0]        hdr_hi;
   logic [15:0]       count_n;
   logic [1:0]        byte_idx;
   logic [31:0]       word;
   logic [ADDR_W:0]   wcount;
   logic              accept;
   logic [15:0]       hdr_n;
   logic              last_word;

   assign accept    = in_valid & in_ready;
   assign hdr_n     = {hdr_hi, in_data};
   // Widen both sides so the final-word test never wraps, even when N == MAX_WORDS.
   assign last_word = (17'(wcount) + 17'd1) == {1'b0, count_n};

   assign init_address     = wcount[ADDR_W-1:0];
   assign init_instruction = word;
   assign words_written    = wcount;

   always_ff @(posedge clk) begin
      if (reset) state <= S_HDR_HI;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      in_ready     = 1'b0;
      write_enable = 1'b0;
      init_mode    = 1'b1;
      done         = 1'b0;
      error        = 1'b0;
      case (state)
         S_HDR_HI: begin
            in_ready = ~reset;
            if (accept) state_nxt = S_HDR_LO;
         end
         S_HDR_LO: begin
            in_ready = ~reset;
            if (accept) begin
               if (hdr_n == 16'd0)             state_nxt = S_DONE;
               else if ({1'b0, hdr_n} > MAX_N) state_nxt = S_ERR;
               else                            state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            in_ready = ~reset;
            if (accept && byte_idx == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            write_enable = 1'b1;
            state_nxt    = last_word ? S_DONE : S_DATA;
         end
         S_DONE: begin
            init_mode = 1'b0;
            done      = 1'b1;
            if (reload) state_nxt = S_HDR_HI;
         end
         S_ERR: begin
            error = 1'b1;
            if (reload) state_nxt = S_HDR_HI;
         end
         default: state_nxt = S_HDR_HI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hdr_hi   <= '0;
         count_n  <= '0;
         byte_idx <= '0;
         word     <= '0;
         wcount   <= '0;
      end else begin
         case (state)
            S_HDR_HI: if (accept) hdr_hi <= in_data;
            S_HDR_LO: begin
               if (accept) begin
                  count_n  <= hdr_n;
                  byte_idx <= '0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  word     <= {word[23:0], in_data};
                  byte_idx <= byte_idx + 2'd1;
               end
            end
            S_WRITE: wcount <= wcount + W_ONE;
            S_DONE, S_ERR: begin
               if (reload) begin
                  wcount   <= '0;
                  byte_idx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   a_we_single: assert property (@(posedge clk) disable iff (reset)
      write_enable |=> !write_enable);
   a_ready_idle: assert property (@(posedge clk)
      (write_enable || done || error) |-> !in_ready);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of whole-image loads plus hand-written corner
// sequences; write strobes are checked against a queue of expected writes.
module tb_imem_loader;
   localparam int MW = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset, in_valid, reload;
   logic [7:0]    in_data;
   logic          in_ready, init_mode, write_enable, done, error;
   logic [AW-1:0] init_address;
   logic [31:0]   init_instruction;
   logic [AW:0]   words_written;

   imem_loader #(.MAX_WORDS(MW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .reload(reload), .init_mode(init_mode),
      .write_enable(write_enable), .init_address(init_address),
      .init_instruction(init_instruction), .words_written(words_written),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   typedef struct {
      logic [15:0]       n;
      bit                gap;
      bit                exp_done;
      bit                exp_err;
      int                exp_ww;
      logic [7:0][31:0]  w;
   } vec_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0, failures = 0;
   int   cyc = 0, last_we_cyc = 0, we_gap = 0, exp_idx = 0;
   logic prev_we = 1'b0;
   vec_t vec[8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (write_enable) begin
         chk("we_single_cycle", 64'(prev_we), 64'd0);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write got addr=%0h data=%0h exp none", init_address, init_instruction);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", 64'(init_address), 64'(e.addr));
            chk("wr_data", 64'(init_instruction), 64'(e.data));
         end
         we_gap      = cyc - last_we_cyc;
         last_we_cyc = cyc;
      end
      prev_we = write_enable;
   end

   // All driving tasks start and end at a falling edge.
   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      sb.delete();
      exp_idx = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int budget = 0;
      if (gap) repeat ($urandom_range(0, 3)) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && budget < 40) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL send_byte_timeout got in_ready=0 exp 1 byte=%0h", b);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int b = 0; b < 4; b++) begin
         if (b == 3) begin
            sb.push_back('{addr: exp_idx[AW-1:0], data: w});
            exp_idx++;
         end
         send_byte(w[31-8*b -: 8], gap);
      end
   endtask

   task automatic wait_status();
      int budget = 0;
      while (!(done || error) && budget < 60) begin
         @(negedge clk);
         budget++;
      end
      if (!(done || error)) begin
         checks++;
         failures++;
         $display("FAIL wait_status_timeout got done=0 error=0 exp one set");
      end
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   function automatic vec_t mkv(input logic [15:0] n, input bit gap, input bit d,
                                input bit er, input int ww);
      vec_t v;
      v.n = n; v.gap = gap; v.exp_done = d; v.exp_err = er; v.exp_ww = ww; v.w = '0;
      return v;
   endfunction

   initial begin
      vec[0] = mkv(16'd2, 0, 1, 0, 2);
      vec[0].w[0] = 32'h20080005; vec[0].w[1] = 32'h01095020;
      vec[1] = mkv(16'd0, 0, 1, 0, 0);
      vec[2] = mkv(16'h1001, 0, 0, 1, 0);
      vec[3] = vec[0]; vec[3].gap = 1;
      vec[4] = mkv(16'd3, 1, 1, 0, 3);
      vec[4].w[0] = 32'hDEADBEEF; vec[4].w[1] = 32'h12345678; vec[4].w[2] = 32'hCAFEF00D;
      vec[5] = mkv(16'd8, 0, 1, 0, 8);
      for (int k = 0; k < 8; k++) vec[5].w[k] = 32'hA0000001 + 32'(k) * 32'h01010101;
      vec[6] = mkv(16'd9, 0, 0, 1, 0);
      vec[7] = mkv(16'hFFFF, 1, 0, 1, 0);

      // Reset state, with a byte offered during reset.
      reset = 1'b1; reload = 1'b0; in_valid = 1'b1; in_data = 8'h55;
      @(negedge clk); @(negedge clk);
      chk("rst_init_mode", 64'(init_mode), 64'd1);
      chk("rst_we", 64'(write_enable), 64'd0);
      chk("rst_addr", 64'(init_address), 64'd0);
      chk("rst_instr", 64'(init_instruction), 64'd0);
      chk("rst_ww", 64'(words_written), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 8; i++) begin
         do_reset();
         send_byte(vec[i].n[15:8], vec[i].gap);
         send_byte(vec[i].n[7:0], vec[i].gap);
         if (vec[i].exp_ww == 0) begin
            chk("hdr_only_done", 64'(done), 64'(vec[i].exp_done));
            chk("hdr_only_error", 64'(error), 64'(vec[i].exp_err));
         end
         for (int k = 0; k < vec[i].exp_ww; k++) send_word(vec[i].w[k], vec[i].gap);
         wait_status();
         chk($sformatf("v%0d_done", i), 64'(done), 64'(vec[i].exp_done));
         chk($sformatf("v%0d_error", i), 64'(error), 64'(vec[i].exp_err));
         chk($sformatf("v%0d_init_mode", i), 64'(init_mode), 64'(!vec[i].exp_done));
         chk($sformatf("v%0d_ww", i), 64'(words_written), 64'(vec[i].exp_ww));
         chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd0);
         chk($sformatf("v%0d_all_writes", i), 64'(sb.size()), 64'd0);
      end

      // Back-to-back timing: strobes 5 cycles apart, done the cycle after the last one.
      do_reset();
      send_byte(8'h00, 0); send_byte(8'h02, 0);
      in_valid = 1'b1;
      send_word(32'h20080005, 0);
      send_word(32'h01095020, 0);
      wait_status();
      chk("strobe_spacing", 64'(we_gap), 64'd5);
      chk("done_latency", 64'(cyc - last_we_cyc), 64'd1);

      // Over limit, then reload back to header, then a small load.
      do_reset();
      send_byte(8'h10, 0); send_byte(8'h01, 0);
      repeat (3) @(negedge clk);
      chk("err_hold", 64'(error), 64'd1);
      chk("err_init_mode", 64'(init_mode), 64'd1);
      chk("err_in_ready", 64'(in_ready), 64'd0);
      pulse_reload();
      chk("err_reload_error", 64'(error), 64'd0);
      chk("err_reload_ready", 64'(in_ready), 64'd1);
      chk("err_reload_init_mode", 64'(init_mode), 64'd1);
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_word(32'h0BADC0DE, 0);
      wait_status();
      chk("after_err_done", 64'(done), 64'd1);

      // Reset mid-word: partial word discarded, reload starts at address 0.
      do_reset();
      send_byte(8'h00, 0); send_byte(8'h02, 0);
      send_byte(8'h20, 0); send_byte(8'h08, 0);
      do_reset();
      send_byte(8'h00, 0); send_byte(8'h02, 1);
      send_word(32'h20080005, 1);
      send_word(32'h01095020, 1);
      wait_status();
      chk("midrst_done", 64'(done), 64'd1);
      chk("midrst_ww", 64'(words_written), 64'd2);
      chk("midrst_all_writes", 64'(sb.size()), 64'd0);

      // Reload after DONE.
      pulse_reload();
      chk("reload_done", 64'(done), 64'd0);
      chk("reload_init_mode", 64'(init_mode), 64'd1);
      chk("reload_ww", 64'(words_written), 64'd0);
      exp_idx = 0;
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_word(32'hAABBCCDD, 0);
      wait_status();
      chk("reload_load_done", 64'(done), 64'd1);
      chk("reload_load_ww", 64'(words_written), 64'd1);
      chk("reload_all_writes", 64'(sb.size()), 64'd0);

      // Reload mid-word is ignored.
      do_reset();
      send_byte(8'h00, 0); send_byte(8'h01, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0);
      pulse_reload();
      sb.push_back('{addr: '0, data: 32'h11223344});
      send_byte(8'h33, 0); send_byte(8'h44, 0);
      wait_status();
      chk("ign_reload_done", 64'(done), 64'd1);
      chk("ign_reload_ww", 64'(words_written), 64'd1);
      chk("ign_reload_all_writes", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that drives the instruction-memory write port of the single-cycle core (`init_mode`, `write_enable`, `init_address`, `init_instruction`). It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, writes them to consecutive word addresses starting at 0, and holds the core in init mode until the image is complete. It sits between a byte source (UART receiver, JTAG FIFO, testbench) and `iitk_mini_mips`.

## Interface
- `MAX_WORDS`, default 4096: instruction-memory capacity in words.
- `ADDR_W`, default 12: width of `init_address`.
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: `in_data` holds a byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `reload` input 1: single-cycle request to load a new image. Honoured only in DONE or ERR.
- `init_mode` output 1: drives the core's `init_mode`. High while loading, which holds the PC.
- `write_enable` output 1: one-cycle write strobe to instruction memory.
- `init_address` output ADDR_W: word index of the current write.
- `init_instruction` output 32: assembled word.
- `words_written` output ADDR_W+1: count of words committed so far in the current load.
- `done` output 1: image loaded; the core is running.
- `error` output 1: header word count exceeded `MAX_WORDS`.

## Operation
- **Stream format:** 2-byte header holding the word count N (big-endian, high byte first), followed by N×4 data bytes. Each word arrives MSB first.
- **Handshake:** a byte transfers on a cycle where `in_valid && in_ready`. The source may hold `in_valid` low for any number of cycles. Bytes presented while `in_ready=0` are neither consumed nor dropped.
- **State machines:**
  - **HDR_HI:** accept the high count byte, then go to HDR_LO.
  - **HDR_LO:** accept the low count byte. Then:
    - If N=0, go to DONE.
    - If N>MAX_WORDS, go to ERR.
    - Otherwise go to DATA with the byte index set to 0.
  - **DATA:** accept bytes into a shift register, `word <= {word[23:0], in_data}`. When the 4th byte is accepted, go to WRITE.
  - **WRITE:** hold `write_enable=1` for exactly one cycle, with `init_address` equal to the current word index and `init_instruction` equal to the assembled word. On exit, increment the word index and `words_written`. If `words_written+1 == N`, go to DONE; otherwise go to DATA.
  - **DONE:**
    - `init_mode=0` and `done=1`.
    - `reload` clears the word index, `words_written`, and `done`, then goes to HDR_HI with `init_mode=1`.
    - Memory contents are not cleared on reload; words beyond the new N keep their old values.
  - **ERR:**
    - `error=1` and `init_mode` stays 1, so the core remains halted.
    - `reload` clears `error` and goes to HDR_HI.
- **`in_ready` by state:**
  - 1 in HDR_HI, HDR_LO and DATA.
  - 0 in WRITE, DONE and ERR.
  - 0 in any cycle where `reset=1`.
- **Unused upper bits:**
  - `init_address` equals the word index truncated to ADDR_W.
  - N is compared as a 16-bit unsigned value.
  - N=MAX_WORDS is legal. The final write uses address MAX_WORDS−1, and the index never wraps during a legal load.

## Timing
- **Reset values (cycle after reset is sampled high):**
  - State HDR_HI.
  - `init_mode=1`, `write_enable=0`, `init_address=0`, `init_instruction=0`.
  - `words_written=0`, `done=0`, `error=0`.
- **Reset mid-load:** same values apply. The partial word is discarded and the next accepted byte is treated as header high.
- **Reset with the core:** the instruction memory clears on its own reset. Reset both blocks together so the loader starts writing after the clear.
- **Write timing:** `write_enable` rises the cycle after the 4th byte of a word is accepted, and is never high on two consecutive cycles. `init_address` and `init_instruction` are stable during the strobe cycle.
- **Peak throughput:** one word per 5 cycles (4 accept cycles plus 1 WRITE cycle).
- **End of load:** `init_mode` falls and `done` rises in the cycle after the final WRITE cycle. The core's PC advances from that edge on.
- **Empty image (N=0):** `done` rises the cycle after HDR_LO accepts its byte, with no writes.
- **Over-limit header:** `error` rises the cycle after HDR_LO accepts its byte.
- **`reload` outside DONE/ERR:** ignored.
- **`reload` together with `reset`:** reset wins.

## Test plan
- **Two-word load:** stream 00 02, 20 08 00 05, 01 09 50 20 with `in_valid` held high. Expect:
  - Strobe at address 0 with 0x20080005.
  - Strobe at address 1 with 0x01095020, 5 cycles later.
  - `done=1` and `init_mode=0` the next cycle; `words_written=2`.
- **Zero count:** stream 00 00. Expect no `write_enable` and `done=1` one cycle after the 2nd byte.
- **Over limit:** stream 10 01 (N=4097). Expect `error=1`, `init_mode` stays 1, `in_ready=0`. Then pulse `reload` and expect `error=0`, `in_ready=1`.
- **Gapped source:** the two-word load with `in_valid` low on random cycles, and bytes held while `in_ready=0`. Expect identical writes with no dropped or duplicated bytes.
- **Reset mid-word:** assert `reset` after 2 data bytes of word 0, then send the full two-word stream. Expect only the new stream's writes, starting at address 0.
- **Reload after DONE:** pulse `reload`, stream 00 01, AA BB CC DD. Expect one write at address 0 with 0xAABBCCDD, then `done=1`.
